// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Produces {remainder, quotient} for the HI/LO write port.
module div_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              signed_div,
  input  logic              annul,
  input  logic [DATA_W-1:0] opdata1,
  input  logic [DATA_W-1:0] opdata2,
  output logic [2*DATA_W-1:0] result,
  output logic              ready,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [2*DATA_W-1:0] w_q, w_nx;
  logic [DATA_W:0]     w_sh_hi, diff;
  logic [DATA_W-1:0]   dvs_q, abs1, abs2;
  logic [DATA_W-1:0]   q_fix, r_fix;
  logic [5:0]          cnt_q;
  logic                qneg_q, rneg_q;
  logic                accept, last;

  assign accept = start && !annul;
  assign last   = (cnt_q == 6'd31);

  assign abs1 = (signed_div && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
  assign abs2 = (signed_div && opdata2[DATA_W-1]) ? -opdata2 : opdata2;

  // A borrow out of the trial subtraction means the divisor did not fit.
  assign w_sh_hi = w_q[2*DATA_W-1:DATA_W-1];
  assign diff    = w_sh_hi - {1'b0, dvs_q};

  always_comb begin
    w_nx = {w_q[2*DATA_W-2:0], 1'b0};
    if (!diff[DATA_W])
      w_nx = {diff[DATA_W-1:0], w_q[DATA_W-2:0], 1'b1};
  end

  assign q_fix = qneg_q ? -w_nx[DATA_W-1:0] : w_nx[DATA_W-1:0];
  assign r_fix = rneg_q ? -w_nx[2*DATA_W-1:DATA_W]
                        :  w_nx[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = (opdata2 == '0) ? DONE : BUSY;
      end
      BUSY: begin
        if (annul)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_q    <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      result <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            w_q    <= {{DATA_W{1'b0}}, abs1};
            dvs_q  <= abs2;
            cnt_q  <= '0;
            qneg_q <= signed_div &
                      (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
            rneg_q <= signed_div & opdata1[DATA_W-1];
            if (opdata2 == '0) result <= '0;
          end
        end
        BUSY: begin
          if (!annul) begin
            w_q   <= w_nx;
            cnt_q <= cnt_q + 6'd1;
            if (last) result <= {r_fix, q_fix};
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state_q == DONE);
  assign busy  = (state_q == BUSY);

endmodule

// File: tb/tb_div_iter.sv
// Directed vector bench for div_iter.
// Latency is counted from the edge that samples start.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic        annul = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic [63:0] result;
  logic        ready;
  logic        busy;

  int npass = 0;
  int ntot  = 0;

  div_iter dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // got = cycle index after the sampling edge where ready shows; -1 on timeout
  task automatic wait_ready(output int got, output int nb);
    got = -1;
    nb  = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (ready) begin
        got = k;
        break;
      end
    end
  endtask

  int got, nb, nrdy;
  logic [63:0] prev;

  initial begin
    tv[0] = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14}};
    tv[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,        {32'hFFFFFFFF, 32'hFFFFFFFD}};
    tv[2] = '{1'b1, 32'd7,          32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}};
    tv[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, {32'h0,        32'h80000000}};
    tv[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,        {32'h0,        32'hFFFFFFFF}};
    tv[5] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9, {32'hFFFFFFFE, 32'h0000000E}};
    tv[6] = '{1'b0, 32'hFFFFFFF9,   32'd2,        {32'h00000001, 32'h7FFFFFFC}};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {63'b0, ready}, 64'd0);
    chk("rst_busy",  {63'b0, busy},  64'd0);
    chk("rst_result", result, 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      start = 1'b1;
      signed_div = tv[i].sd;
      opdata1 = tv[i].a;
      opdata2 = tv[i].b;
      @(posedge clk);
      #1 start = 1'b0;
      wait_ready(got, nb);
      chk($sformatf("v%0d_lat", i), 64'(got), 64'd32);
      chk($sformatf("v%0d_res", i), result, tv[i].exp);
      chk($sformatf("v%0d_busy", i), 64'(nb), 64'd32);
      @(negedge clk);
      chk($sformatf("v%0d_pulse", i), {63'b0, ready}, 64'd0);
    end
    prev = tv[6].exp;

    // annul in the 10th BUSY cycle, then an immediate new start
    @(negedge clk);
    start = 1'b1;
    signed_div = 1'b0;
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    nrdy = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    @(negedge clk);
    chk("annul_ready", 64'(nrdy + int'(ready)), 64'd0);
    chk("annul_busy", {63'b0, busy}, 64'd0);
    chk("annul_result", result, prev);
    start = 1'b1;
    opdata1 = 32'd9;
    opdata2 = 32'd4;
    @(posedge clk);
    #1 start = 1'b0;
    wait_ready(got, nb);
    chk("restart_lat", 64'(got), 64'd32);
    chk("restart_res", result, {32'd1, 32'd2});

    // divide by zero: start raised just after E0, first sampled at E1
    @(posedge clk);
    #1;
    start = 1'b1;
    signed_div = 1'b1;
    opdata1 = 32'd123;
    opdata2 = 32'd0;
    @(negedge clk);
    nb = int'(busy);
    chk("div0_early", {63'b0, ready}, 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    nb += int'(busy);
    chk("div0_ready", {63'b0, ready}, 64'd1);
    chk("div0_res", result, 64'd0);
    @(negedge clk);
    nb += int'(busy);
    chk("div0_pulse", {63'b0, ready}, 64'd0);
    chk("div0_busy", 64'(nb), 64'd0);

    // start held through BUSY and DONE yields exactly one result
    @(negedge clk);
    start = 1'b1;
    signed_div = 1'b0;
    opdata1 = 32'd50;
    opdata2 = 32'd5;
    @(posedge clk);
    wait_ready(got, nb);
    start = 1'b0;
    chk("held_lat", 64'(got), 64'd32);
    chk("held_res", result, {32'd0, 32'd10});
    nrdy = 0;
    nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) nrdy++;
      if (busy) nb++;
    end
    chk("held_extra_ready", 64'(nrdy), 64'd0);
    chk("held_extra_busy", 64'(nb), 64'd0);

    // reset in the 20th BUSY cycle
    @(negedge clk);
    start = 1'b1;
    opdata1 = 32'd1000;
    opdata2 = 32'd3;
    @(posedge clk);
    #1;
    repeat (20) @(negedge clk);
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    resetn = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", {63'b0, ready}, 64'd0);
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_result", result, 64'd0);
    resetn = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ready) nrdy++;
    end
    chk("post_rst_ready", 64'(nrdy), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
